// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N:1 multiplexer.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Ceiling log2 with a floor of 1 so single-bit fields never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational WIDTH-bit CHANNELS:1 mux; out-of-range selects yield zero data and a flag.
module mux_nto1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      oor_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_i == SEL_W'(k)) data_o = data_i[k*WIDTH +: WIDTH];
        end
    end

    assign oor_o = (int'(sel_i) >= CHANNELS);

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered CHANNELS:1 mux with manual select or an auto sweep over a latched channel mask.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 1,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto,
    input  logic [CHANNELS-1:0]       mask,
    input  logic                      start,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      valid,
    output logic                      busy,
    output logic                      done
);

    localparam int                CNT_W      = clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;

    logic [SEL_W-1:0]    mux_sel;
    logic [WIDTH-1:0]    mux_data;
    logic                mux_oor;
    logic [SEL_W-1:0]    first_ch;
    logic [SEL_W-1:0]    next_ch;
    logic                none_left;
    logic                advance;

    // Lowest set bit of the incoming mask, and of the latched mask above the current channel.
    always_comb begin
        first_ch  = '0;
        next_ch   = '0;
        none_left = 1'b1;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (mask[k]) first_ch = SEL_W'(k);
            if (mask_q[k] && (k > int'(out_ch_q))) begin
                next_ch   = SEL_W'(k);
                none_left = 1'b0;
            end
        end
    end

    assign advance = (dwell_q == DWELL_LAST);

    // The mux always looks at the channel that will be presented after this edge.
    always_comb begin
        if (state_q == SCAN) begin
            mux_sel = (advance && !none_left) ? next_ch : out_ch_q;
        end else if (auto) begin
            mux_sel = first_ch;
        end else begin
            mux_sel = sel;
        end
    end

    mux_nto1 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data_i (in),
        .sel_i  (mux_sel),
        .data_o (mux_data),
        .oor_o  (mux_oor)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out_ch_d = out_ch_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (!auto) begin
                    out_d    = mux_data;
                    out_ch_d = sel;
                    valid_d  = !mux_oor;
                end else if (start && (mask != '0)) begin
                    state_d  = SCAN;
                    mask_d   = mask;
                    out_ch_d = first_ch;
                    out_d    = mux_data;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    dwell_d  = '0;
                end else begin
                    valid_d = 1'b0;
                    done_d  = start;
                end
            end
            SCAN: begin
                if (!auto) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (advance && none_left) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dwell_d = '0;
                end else if (advance) begin
                    out_ch_d = next_ch;
                    out_d    = mux_data;
                    dwell_d  = '0;
                end else begin
                    out_d   = mux_data;
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
        end
    end

    assign out    = out_q;
    assign out_ch = out_ch_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench: three instances cover 8ch/DWELL=2, 8ch/DWELL=3 and 5ch/DWELL=1.
module tb_mux_scan_nto1;

    typedef struct {
        logic [7:0] out;
        logic [2:0] ch;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [63:0] in_a, in_b;
    logic [39:0] in_c;
    logic [2:0]  sel_a = '0, sel_b = '0, sel_c = '0;
    logic        auto_a = 1'b0, auto_b = 1'b0, auto_c = 1'b0;
    logic [7:0]  mask_a = '0, mask_b = '0;
    logic [4:0]  mask_c = '0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [7:0]  out_a, out_b, out_c;
    logic [2:0]  ch_a, ch_b, ch_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.WIDTH(8), .CHANNELS(8), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .sel(sel_a), .auto(auto_a), .mask(mask_a),
        .start(start_a), .out(out_a), .out_ch(ch_a), .valid(valid_a), .busy(busy_a),
        .done(done_a)
    );

    mux_scan_nto1 #(.WIDTH(8), .CHANNELS(8), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .sel(sel_b), .auto(auto_b), .mask(mask_b),
        .start(start_b), .out(out_b), .out_ch(ch_b), .valid(valid_b), .busy(busy_b),
        .done(done_b)
    );

    mux_scan_nto1 #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst), .in(in_c), .sel(sel_c), .auto(auto_c), .mask(mask_c),
        .start(start_c), .out(out_c), .out_ch(ch_c), .valid(valid_c), .busy(busy_c),
        .done(done_c)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] o, input logic [2:0] ch,
                            input logic v, input logic b, input logic d);
        exp_t e;
        e.out = o; e.ch = ch; e.valid = v; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    // Expected trace of a full sweep: dwell cycles per enabled channel, the done cycle, one idle cycle.
    task automatic push_sweep(input logic [7:0] msk, input int nch, input int dwell,
                              input logic [7:0] base);
        logic [7:0] last_out;
        logic [2:0] last_ch;
        last_out = '0;
        last_ch  = '0;
        for (int k = 0; k < nch; k++) begin
            if (msk[k]) begin
                for (int d = 0; d < dwell; d++) push_exp(base + 8'(k), 3'(k), 1'b1, 1'b1, 1'b0);
                last_out = base + 8'(k);
                last_ch  = 3'(k);
            end
        end
        push_exp(last_out, last_ch, 1'b0, 1'b0, 1'b1);
        push_exp(last_out, last_ch, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag, input int which);
        exp_t       e;
        logic [7:0] o;
        logic [2:0] ch;
        logic       v, b, d;
        case (which)
            0:       begin o = out_a; ch = ch_a; v = valid_a; b = busy_a; d = done_a; end
            1:       begin o = out_b; ch = ch_b; v = valid_b; b = busy_b; d = done_b; end
            default: begin o = out_c; ch = ch_c; v = valid_c; b = busy_c; d = done_c; end
        endcase
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_out"},   32'(o),  32'(e.out));
        check({tag, "_ch"},    32'(ch), 32'(e.ch));
        check({tag, "_valid"}, 32'(v),  32'(e.valid));
        check({tag, "_busy"},  32'(b),  32'(e.busy));
        check({tag, "_done"},  32'(d),  32'(e.done));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            in_a[k*8 +: 8] = 8'h10 + 8'(k);
            in_b[k*8 +: 8] = 8'h20 + 8'(k);
        end
        for (int k = 0; k < 5; k++) in_c[k*8 +: 8] = 8'h50 + 8'(k);

        // Reset state of every instance.
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            push_exp(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            pop_check($sformatf("reset_%0d", i), i);
        end
        rst = 1'b0;

        // Manual stepping on the 8-channel instance.
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            push_exp(8'h10 + 8'(s), 3'(s), 1'b1, 1'b0, 1'b0);
            tick();
            pop_check($sformatf("manual_sel%0d", s), 0);
        end

        // Full sweep, mask=FF, DWELL=2.
        auto_a = 1'b1; mask_a = 8'hFF; start_a = 1'b1;
        push_sweep(8'hFF, 8, 2, 8'h10);
        for (int i = 0; i < 18; i++) begin
            tick();
            start_a = 1'b0;
            pop_check($sformatf("full_%0d", i), 0);
        end

        // Sparse sweep with mask and start disturbances mid-sweep.
        auto_b = 1'b1; mask_b = 8'b1000_0101; start_b = 1'b1;
        push_sweep(8'b1000_0101, 8, 3, 8'h20);
        for (int i = 0; i < 11; i++) begin
            tick();
            start_b = 1'b0;
            if (i == 3) begin mask_b = 8'hFF; start_b = 1'b1; end
            pop_check($sformatf("sparse_%0d", i), 1);
        end

        // Abort during channel 2: valid/busy fall, no done, manual resumes next edge.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre_ch", 32'(ch_a), 32'd2);
        check("abort_pre_valid", 32'(valid_a), 32'd1);
        auto_a = 1'b0; sel_a = 3'd3;
        push_exp(8'h12, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        pop_check("abort_edge", 0);
        push_exp(8'h13, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        pop_check("abort_manual", 0);

        // Start with an empty mask: done pulse only.
        auto_a = 1'b1; mask_a = 8'h00; start_a = 1'b1;
        push_exp(8'h13, 3'd3, 1'b0, 1'b0, 1'b1);
        tick();
        start_a = 1'b0;
        pop_check("mask0_done", 0);
        push_exp(8'h13, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        pop_check("mask0_after", 0);

        // Five-channel instance: out-of-range selects and a short sweep.
        sel_c = 3'd6;
        push_exp(8'h00, 3'd6, 1'b0, 1'b0, 1'b0);
        tick();
        pop_check("c_sel6", 2);
        sel_c = 3'd4;
        push_exp(8'h54, 3'd4, 1'b1, 1'b0, 1'b0);
        tick();
        pop_check("c_sel4", 2);
        sel_c = 3'd5;
        push_exp(8'h00, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        pop_check("c_sel5", 2);
        auto_c = 1'b1; mask_c = 5'b10010; start_c = 1'b1;
        push_sweep(8'b0001_0010, 5, 1, 8'h50);
        for (int i = 0; i < 4; i++) begin
            tick();
            start_c = 1'b0;
            pop_check($sformatf("c_sweep_%0d", i), 2);
        end

        // Asynchronous reset mid-sweep.
        mask_a = 8'hFF; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_pre_busy", 32'(busy_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_out",   32'(out_a),   32'd0);
        check("rst_async_ch",    32'(ch_a),    32'd0);
        check("rst_async_valid", 32'(valid_a), 32'd0);
        check("rst_async_busy",  32'(busy_a),  32'd0);
        check("rst_async_done",  32'(done_a),  32'd0);
        check("rst_async_state", 32'(dut_a.state_q), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("rst_after_done", 32'(done_a), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
